// File: rtl/cond_pkg.sv
// Shared encodings for the conditional-execution stage: condition codes, NZCV bit positions, FlagW fields.
// Holds only constants, so it has no latency and no backpressure.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_CV   = 2'b01;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/condcheck.sv
// Evaluates a condition field against stored NZCV flags.
// Purely combinational: zero latency, no backpressure.
module condcheck
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = !z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = !c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = !n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = !v;
      COND_HI: CondEx = c & !z;
      COND_LS: CondEx = !c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = !z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution stage: NZCV register plus condition gating of PCS/RegW/MemW.
// Strobes are combinational (same cycle); flags update on the next rising edge; no backpressure.
module condlogic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic cond_ex;
  logic write_nz;
  logic write_cv;

  // Condition is judged on the stored flags, so a flag-setting conditional
  // instruction sees the results of earlier instructions, not its own.
  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  assign write_nz = cond_ex && ((FlagW & FLAGW_NZ) != FLAGW_NONE);
  assign write_cv = cond_ex && ((FlagW & FLAGW_CV) != FLAGW_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= FLAGS_RST;
    end else begin
      if (write_nz) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (write_cv) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign PCSrc    = PCS  & cond_ex & !reset;
  assign RegWrite = RegW & cond_ex & !NoWrite & !reset;
  assign MemWrite = MemW & cond_ex & !reset;

endmodule

// File: tb/tb_condlogic.sv
// Scoreboard bench for condlogic: each driven instruction pushes its expected strobes and next flags.
module tb_condlogic;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite;
  logic [3:0] Flags;

  typedef struct {
    logic [2:0] strb;
    logic [3:0] flg;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_flags = 4'b0000;

  condlogic #(.FLAGS_RST(4'b0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Pairs of codes share a base predicate; the odd code is its inverse.
  function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic step(input string tag, input logic [3:0] c, input logic [3:0] a,
                      input logic [1:0] fw, input logic pcs, input logic regw,
                      input logic memw, input logic nw, input logic rst);
    exp_t       e;
    exp_t       got;
    logic       cx;
    logic [2:0] obs;
    @(negedge clk);
    Cond = c; ALUFlags = a; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nw; reset = rst;
    cx = cond_model(model_flags, c);
    e.strb = rst ? 3'b000 : {pcs & cx, regw & cx & ~nw, memw & cx};
    e.flg  = model_flags;
    if (rst) e.flg = 4'b0000;
    else begin
      if (fw[1] && cx) e.flg[3:2] = a[3:2];
      if (fw[0] && cx) e.flg[1:0] = a[1:0];
    end
    sb_q.push_back(e);
    #1;
    obs = {PCSrc, RegWrite, MemWrite};
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_strb"}, {1'b0, obs}, {1'b0, got.strb});
      check({tag, "_flags"}, Flags, got.flg);
      model_flags = got.flg;
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    step("setf", 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;

    step("reset", 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_flags_zero", Flags, 4'b0000);

    step("split_nz", 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("split_nz_val", Flags, 4'b1100);
    step("split_cv", 4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("split_cv_val", Flags, 4'b1111);

    set_flags(4'b0000);
    step("old_eq", 4'b0000, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("old_eq_keep", Flags, 4'b0000);
    step("old_al", 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("old_al_cap", Flags, 4'b0100);

    set_flags(4'b0000);
    step("cmp", 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("cmp_flags", Flags, 4'b0110);
    step("hi_after_cmp", 4'b1000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    set_flags(4'b1000);
    step("lt", 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ge", 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    set_flags(4'b1001);
    step("gt", 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    set_flags(4'b1111);
    step("mid_reset", 4'b1110, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    set_flags(4'b0101);
    step("x_alu", 4'b1110, 4'bxxxx, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("nv_never", 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++)
        step("sweep", 4'(c), 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/condlogic.md
Name: condlogic

Overview:
- Conditional-execution stage directly downstream of the single-cycle ALU.
- Holds the architectural NZCV flags register and captures ALUFlags when an instruction's condition passes and its FlagW bits are set.
- Evaluates the instruction's Cond field against the stored flags.
- Gates the decoder's PCS/RegW/MemW into the PCSrc/RegWrite/MemWrite strobes seen by the datapath and memory.

Parameters:
- FLAGS_RST, 4'b0000, value loaded into the NZCV register on reset, ordered {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  [1] = write N,Z; [0] = write C,V (from decoder).
- PCS  input  1  instruction writes the PC (branch, or Rd=R15).
- RegW  input  1  instruction writes the register file.
- MemW  input  1  instruction writes data memory.
- NoWrite  input  1  compare-type instruction (CMP/TST); suppresses RegWrite.
- PCSrc  output  1  gated PC-write select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated data-memory write enable.
- Flags  output  4  current stored {N,Z,C,V}, for debug and testbench observation.

Behaviour:
- Flags register: 4 bits, {N,Z,C,V}.
  - Synchronous reset: when reset=1 at a posedge, Flags <= FLAGS_RST.
  - Flags reads 4'b0000 after reset with the default parameter.
- CondEx is combinational, computed from the stored Flags, never from ALUFlags. The current instruction's condition uses the flags left by earlier instructions.
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1.
  - 1111 (NV/unpredictable) gives 0 (never executes). Never X.
- Flag update at posedge when reset=0:
  - Flags[3:2] <= ALUFlags[3:2] iff FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondEx.
  - The two halves update independently. A failed condition updates nothing.
- Flag convention matches the ALU: C after SUB/CMP is 1 for no borrow; C and V are 0 after logical ops. The block stores these values without reinterpreting them.
- Output strobes are combinational, with zero latency in the same cycle:
  - PCSrc = PCS & CondEx & !reset.
  - RegWrite = RegW & CondEx & !NoWrite & !reset.
  - MemWrite = MemW & CondEx & !reset.
- Reset mid-operation: all three strobes are 0 for the whole reset cycle, regardless of the other inputs. No flag capture occurs in that cycle.
- Simultaneous events: when an instruction both tests and sets flags (e.g. ADDEQS), CondEx uses the old flags. The new flags are visible in Flags from the next cycle.
- X on ALUFlags is harmless when FlagW=00. Flags must not go X in that case.

Decomposition:
- Shared package cond_pkg:
  - localparams for the 16 condition codes (COND_EQ … COND_NV).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW encodings FLAGW_NONE=2'b00, FLAGW_CV=2'b01, FLAGW_NZ=2'b10, FLAGW_ALL=2'b11.
- One sub-module, condcheck: purely combinational, (Cond, Flags) -> CondEx.
- condlogic holds only the register and the gating logic.

Test Plan:
1. Reset: reset=1 with Cond=1110, PCS=RegW=MemW=1, FlagW=11, ALUFlags=1111 -> PCSrc=RegWrite=MemWrite=0. Next cycle Flags=0000.
2. Flag capture and split: Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 next cycle. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
3. Condition uses old flags: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=0100, RegW=1 -> RegWrite=0 and Flags stays 0000. Same setup with Cond=1110 -> RegWrite=1 and Flags=0100 next cycle.
4. Full condition sweep: for all 16 Flags values × 16 Cond values, check CondEx (observed via RegW=1 -> RegWrite) against the table. Cond=1111 always gives 0.
5. CMP gating: Flags=0000, Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0 and Flags=0110 next cycle. Then Cond=1000 (HI) with PCS=1 -> PCSrc=0, since C&!Z is false with Z=1.
6. Signed compare: Flags=1000 (N=1,V=0), Cond=1011 (LT), MemW=1 -> MemWrite=1. Cond=1010 (GE) -> MemWrite=0. Flags=1001 (N=V=1), Cond=1100 (GT) -> MemWrite=1.
